// File: rtl/attn_pkg.sv
// Shared definitions for the attention stream bridge.
// Holds the bridge state enum, the element-index width helper used to size
// the element-index type idx_t inside the bridge, and the flat-bus offset helper.
package attn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLR,
        ST_KICK,
        ST_WAIT,
        ST_UNLOAD
    } bridge_state_e;

    // Width of an element index able to hold 0..n (one past the last element).
    function automatic int idx_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Bit offset of element k on a flat bus of w-bit elements.
    function automatic int flat_offset(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/attn_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags
// expiry during the limit-th enabled cycle. limit must be at least 1.
module attn_watchdog (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] limit,
    output logic        expired
);

    logic [31:0] count;

    // Expiry is combinational so the owner can leave its wait state in the same cycle.
    assign expired = enable && (({1'b0, count} + 33'd1) >= {1'b0, limit});

    // Cycle counter: cleared on request, advances only while enabled and not yet expired.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every register
        // samples the pre-edge values, independent of statement order.
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/attn_stream_bridge.sv
// Attention stream bridge: collects one job of SEQ_LEN*EMBED_DIM elements from
// an input stream, hands it to a flat-bus engine (reset pulse, start pulse),
// waits for done under a watchdog, then streams the captured result out.
// Optional feature macro: ATTN_BRIDGE_PERF_EN enables the WAIT-cycle perf counter;
// without it perf_cycles is tied to zero.
module attn_stream_bridge
    import attn_pkg::*;
#(
    parameter  int DATA_WIDTH     = 32,
    parameter  int SEQ_LEN        = 64,
    parameter  int EMBED_DIM      = 64,
    parameter  int TIMEOUT_CYCLES = 65536,
    localparam int N              = SEQ_LEN * EMBED_DIM,
    localparam int FLAT_W         = DATA_WIDTH * N
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [FLAT_W-1:0]     eng_tokens_flat,
    output logic                  eng_rst,
    output logic                  eng_start,
    input  logic                  eng_done,
    input  logic [FLAT_W-1:0]     eng_out_flat,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  timeout,
    output logic [31:0]           perf_cycles
);

    localparam int IDX_W = idx_width(N);
    typedef logic [IDX_W-1:0] idx_t;
    localparam idx_t LAST_IDX = idx_t'(N - 1);

    bridge_state_e         state;
    bridge_state_e         state_nxt;
    idx_t                  idx;
    idx_t                  odx;
    logic [FLAT_W-1:0]     in_buf;
    logic [FLAT_W-1:0]     out_buf;
    logic [DATA_WIDTH-1:0] out_elem [N];
    logic                  s_fire;
    logic                  m_fire;
    logic                  idx_last;
    logic                  odx_last;
    logic                  last_mismatch;
    logic                  wd_clear;
    logic                  wd_enable;
    logic                  wd_expired;

    assign s_fire        = s_valid && s_ready;
    assign m_fire        = m_valid && m_ready;
    assign idx_last      = (idx == LAST_IDX);
    assign odx_last      = (odx == LAST_IDX);
    assign last_mismatch = (s_last != idx_last);

    assign eng_tokens_flat = in_buf;
    assign m_last          = m_valid && odx_last;

    attn_watchdog u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .limit   (32'(TIMEOUT_CYCLES)),
        .expired (wd_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_LOAD: if (s_fire) state_nxt = idx_last ? ST_CLR : ST_LOAD;
            ST_CLR:           state_nxt = ST_KICK;
            ST_KICK:          state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (eng_done) begin
                    state_nxt = ST_UNLOAD;
                end else if (wd_expired) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_UNLOAD:        if (m_fire && odx_last) state_nxt = ST_IDLE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs; reset forces the engine into reset and closes both streams.
    always_comb begin
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        eng_rst   = rst;
        eng_start = 1'b0;
        busy      = 1'b0;
        wd_clear  = 1'b0;
        wd_enable = 1'b0;
        if (!rst) begin
            busy = (state != ST_IDLE);
            case (state)
                ST_IDLE, ST_LOAD: s_ready = 1'b1;
                ST_CLR:           eng_rst = 1'b1;
                ST_KICK: begin
                    eng_start = 1'b1;
                    wd_clear  = 1'b1;
                end
                ST_WAIT:          wd_enable = 1'b1;
                ST_UNLOAD:        m_valid = 1'b1;
                default:          ;
            endcase
        end
    end

    // Stream indices and sticky status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            odx       <= '0;
            frame_err <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            if (s_fire) begin
                idx <= idx_last ? '0 : idx + idx_t'(1);
                if (state == ST_IDLE) begin
                    // First beat of a job starts fresh status.
                    frame_err <= last_mismatch;
                    timeout   <= 1'b0;
                end else begin
                    frame_err <= frame_err || last_mismatch;
                end
            end
            if (m_fire) begin
                odx <= odx_last ? '0 : odx + idx_t'(1);
            end
            if (state == ST_WAIT && !eng_done && wd_expired) begin
                timeout <= 1'b1;
            end
        end
    end

    // Per-element input buffer writes and output buffer read view.
    for (genvar k = 0; k < N; k++) begin : g_elem
        localparam int OFF = flat_offset(k, DATA_WIDTH);

        // Element k is written only by the beat carrying index k.
        always_ff @(posedge clk) begin
            // NOTE: job buffers carry no reset; every element is rewritten by
            // the next load or capture before it is ever observed.
            if (s_fire && idx == idx_t'(k)) begin
                in_buf[OFF +: DATA_WIDTH] <= s_data;
            end
        end

        assign out_elem[k] = out_buf[OFF +: DATA_WIDTH];
    end

    // Capture the engine result when done is seen in WAIT.
    always_ff @(posedge clk) begin
        if (state == ST_WAIT && eng_done) begin
            out_buf <= eng_out_flat;
        end
    end

    // Output element select; odx only moves on a handshake, so data holds across stalls.
    always_comb begin
        m_data = '0;
        for (int k = 0; k < N; k++) begin
            if (odx == idx_t'(k)) begin
                m_data = out_elem[k];
            end
        end
    end

`ifdef ATTN_BRIDGE_PERF_EN
    // Perf counter: cleared at kick, counts each WAIT cycle, saturates, holds after capture.
    always_ff @(posedge clk) begin
        if (rst || state == ST_KICK) begin
            perf_cycles <= '0;
        end else if (state == ST_WAIT && perf_cycles != '1) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_attn_stream_bridge.sv
// Self-checking bench for attn_stream_bridge (N = 4 elements of 16 bits).
// Engine model: done three cycles after start, result = input + 1 per element.
module tb_attn_stream_bridge;

    localparam int DW          = 16;
    localparam int SL          = 2;
    localparam int ED          = 2;
    localparam int NE          = SL * ED;
    localparam int FW          = DW * NE;
    localparam int TO          = 8;
    localparam int ENG_LAT     = 3;
    localparam int EXP_LATENCY = ENG_LAT + 3;
`ifdef ATTN_BRIDGE_PERF_EN
    localparam logic [31:0] EXP_PERF    = 32'(ENG_LAT);
    localparam logic [31:0] EXP_PERF_TO = 32'(TO);
`else
    localparam logic [31:0] EXP_PERF    = 32'd0;
    localparam logic [31:0] EXP_PERF_TO = 32'd0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [FW-1:0] eng_tokens_flat;
    logic          eng_rst;
    logic          eng_start;
    logic          eng_done;
    logic [FW-1:0] eng_out_flat;
    logic          busy;
    logic          frame_err;
    logic          timeout;
    logic [31:0]   perf_cycles;

    int checks = 0;
    int errors = 0;
    int n_eng_rst = 0;
    int n_eng_start = 0;
    logic hang = 1'b0;
    logic eng_d1, eng_d2;

    always #5 clk = ~clk;

    attn_stream_bridge #(
        .DATA_WIDTH     (DW),
        .SEQ_LEN        (SL),
        .EMBED_DIM      (ED),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .s_last          (s_last),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_data          (m_data),
        .m_last          (m_last),
        .eng_tokens_flat (eng_tokens_flat),
        .eng_rst         (eng_rst),
        .eng_start       (eng_start),
        .eng_done        (eng_done),
        .eng_out_flat    (eng_out_flat),
        .busy            (busy),
        .frame_err       (frame_err),
        .timeout         (timeout),
        .perf_cycles     (perf_cycles)
    );

    // Engine model: sticky done three cycles after start unless hung.
    always @(posedge clk) begin
        if (eng_rst) begin
            eng_d1   <= 1'b0;
            eng_d2   <= 1'b0;
            eng_done <= 1'b0;
        end else begin
            eng_d1 <= eng_start && !hang;
            eng_d2 <= eng_d1;
            if (eng_d2) eng_done <= 1'b1;
        end
    end

    always_comb begin
        eng_out_flat = '0;
        for (int k = 0; k < NE; k++) begin
            eng_out_flat[k*DW +: DW] = eng_tokens_flat[k*DW +: DW] + 16'd1;
        end
    end

    // Pulse counters for engine control.
    always @(posedge clk) begin
        if (eng_rst) n_eng_rst++;
        if (eng_start) n_eng_start++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [0:3][DW-1:0] din;
        logic [3:0]         lastm;
        int                 stall;
        logic [0:3][DW-1:0] dout;
        logic               ferr;
    } vec_t;

    vec_t vecs [4];

    // Push four beats (random input gaps), ending just after the accepting edge.
    task automatic send_beats(input logic [0:3][DW-1:0] din, input logic [3:0] lastm,
                              input int gap_pct, input string tag);
        int k = 0;
        int budget = 0;
        while (k < NE && budget < 200) begin
            @(negedge clk);
            budget++;
            if ($urandom_range(0, 99) < gap_pct) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = din[k];
                s_last  = lastm[k];
                if (s_ready) k++;
            end
        end
        check({tag, " beats_accepted"}, 32'(k), 32'(NE));
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // One full job: load, engine handshake, unload with stalls, status checks.
    task automatic run_job(input logic [0:3][DW-1:0] din, input logic [3:0] lastm,
                           input int stall_pct, input logic [0:3][DW-1:0] exp_out,
                           input logic exp_ferr, input string tag);
        int lat;
        int rcv;
        int budget;
        logic          prev_stall;
        logic [DW-1:0] prev_d;
        logic          prev_l;
        n_eng_rst   = 0;
        n_eng_start = 0;
        send_beats(din, lastm, stall_pct, tag);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!m_valid && lat < 100);
        check({tag, " latency"}, 32'(lat), 32'(EXP_LATENCY));
        check({tag, " eng_rst_pulses"}, 32'(n_eng_rst), 32'd1);
        check({tag, " eng_start_pulses"}, 32'(n_eng_start), 32'd1);
        check({tag, " perf_cycles"}, perf_cycles, EXP_PERF);
        rcv = 0;
        budget = 0;
        prev_stall = 1'b0;
        prev_d = '0;
        prev_l = 1'b0;
        while (rcv < NE && budget < 200) begin
            if (prev_stall) begin
                check({tag, " stall_valid"}, 32'(m_valid), 32'd1);
                check({tag, " stall_data"}, 32'(m_data), 32'(prev_d));
                check({tag, " stall_last"}, 32'(m_last), 32'(prev_l));
            end
            m_ready = ($urandom_range(0, 99) >= stall_pct);
            if (m_valid && m_ready) begin
                check($sformatf("%s data[%0d]", tag, rcv), 32'(m_data), 32'(exp_out[rcv]));
                check($sformatf("%s last[%0d]", tag, rcv), 32'(m_last), 32'(rcv == NE - 1));
                rcv++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = m_valid;
            end
            prev_d = m_data;
            prev_l = m_last;
            budget++;
            @(negedge clk);
        end
        m_ready = 1'b0;
        check({tag, " beats_received"}, 32'(rcv), 32'(NE));
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
        check({tag, " idle_m_valid"}, 32'(m_valid), 32'd0);
        check({tag, " frame_err"}, 32'(frame_err), 32'(exp_ferr));
        check({tag, " timeout"}, 32'(timeout), 32'd0);
    endtask

    task automatic run_vec(input int i, input string tag);
        run_job(vecs[i].din, vecs[i].lastm, vecs[i].stall, vecs[i].dout, vecs[i].ferr, tag);
    endtask

    initial begin
        logic [0:3][DW-1:0] rdin;
        logic [0:3][DW-1:0] rexp;
        logic [3:0]         rlast;
        logic               saw_mv;
        int                 wait_n;

        vecs[0] = '{din: '{16'h0001, 16'h0002, 16'h0003, 16'h0004}, lastm: 4'b1000, stall: 0,
                    dout: '{16'h0002, 16'h0003, 16'h0004, 16'h0005}, ferr: 1'b0};
        vecs[1] = '{din: '{16'h0010, 16'h0020, 16'h0030, 16'h0040}, lastm: 4'b0010, stall: 50,
                    dout: '{16'h0011, 16'h0021, 16'h0031, 16'h0041}, ferr: 1'b1};
        vecs[2] = '{din: '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000}, lastm: 4'b1000, stall: 50,
                    dout: '{16'h0000, 16'h8000, 16'h8001, 16'h0001}, ferr: 1'b0};
        vecs[3] = '{din: '{16'hA5A5, 16'h5A5A, 16'h1234, 16'hFFFE}, lastm: 4'b1001, stall: 30,
                    dout: '{16'hA5A6, 16'h5A5B, 16'h1235, 16'hFFFF}, ferr: 1'b1};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst s_ready", 32'(s_ready), 32'd0);
        check("rst m_valid", 32'(m_valid), 32'd0);
        check("rst m_last", 32'(m_last), 32'd0);
        check("rst eng_rst", 32'(eng_rst), 32'd1);
        check("rst eng_start", 32'(eng_start), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst s_ready", 32'(s_ready), 32'd1);
        check("post_rst busy", 32'(busy), 32'd0);
        check("post_rst eng_rst", 32'(eng_rst), 32'd0);
        check("post_rst frame_err", 32'(frame_err), 32'd0);
        check("post_rst timeout", 32'(timeout), 32'd0);
        check("post_rst perf", perf_cycles, 32'd0);

        // Table vectors: basic job, early s_last, wrap values, extra s_last.
        for (int i = 0; i < 4; i++) run_vec(i, $sformatf("vec%0d", i));

        // Engine never finishes: watchdog expires after TO WAIT cycles.
        hang = 1'b1;
        send_beats(vecs[0].din, vecs[0].lastm, 0, "to");
        saw_mv = 1'b0;
        for (int c = 1; c <= TO + 3; c++) begin
            @(negedge clk);
            if (m_valid) saw_mv = 1'b1;
            if (c == TO + 2) begin
                check("to busy_in_wait", 32'(busy), 32'd1);
                check("to flag_before", 32'(timeout), 32'd0);
            end
        end
        check("to busy_after", 32'(busy), 32'd0);
        check("to flag_after", 32'(timeout), 32'd1);
        check("to s_ready", 32'(s_ready), 32'd1);
        check("to no_m_valid", 32'(saw_mv), 32'd0);
        check("to perf", perf_cycles, EXP_PERF_TO);
        hang = 1'b0;
        run_vec(0, "after_to");

        // Reset pulsed during unload after two beats.
        send_beats(vecs[2].din, vecs[2].lastm, 0, "rstmid");
        wait_n = 0;
        do begin
            @(negedge clk);
            wait_n++;
        end while (!m_valid && wait_n < 100);
        check("rstmid m_valid", 32'(m_valid), 32'd1);
        check("rstmid first", 32'(m_data), 32'(vecs[2].dout[0]));
        m_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_ready = 1'b0;
        @(negedge clk);
        check("rstmid m_valid_rst", 32'(m_valid), 32'd0);
        check("rstmid busy_rst", 32'(busy), 32'd0);
        check("rstmid s_ready_rst", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstmid s_ready_rel", 32'(s_ready), 32'd1);
        check("rstmid busy_rel", 32'(busy), 32'd0);
        run_vec(0, "after_rstmid");

        // Random jobs against the reference model: out = in + 1, frame error
        // whenever the s_last pattern differs from "only on the final beat".
        for (int j = 0; j < 12; j++) begin
            rlast = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1000;
            for (int k = 0; k < NE; k++) begin
                rdin[k] = DW'($urandom);
                rexp[k] = rdin[k] + 16'd1;
            end
            run_job(rdin, rlast, $urandom_range(0, 60), rexp, rlast != 4'b1000,
                    $sformatf("rand%0d", j));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/attn_stream_bridge.md
ATTN_STREAM_BRIDGE -- requirements
Module: attn_stream_bridge

Interface
REQ-001 Parameters, one per line: DATA_WIDTH, 32, element width, signed fixed point; SEQ_LEN, 64, tokens per job; EMBED_DIM, 64, elements per token; TIMEOUT_CYCLES, 65536, WAIT watchdog limit (must be >= 1).
REQ-002 N = SEQ_LEN*EMBED_DIM elements per job; FLAT_W = DATA_WIDTH*N.
REQ-003 Ports, one per line:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input element valid.
- s_ready  out  1  input element accepted when s_valid&s_ready.
- s_data  in  DATA_WIDTH  input element.
- s_last  in  1  sender marks element N-1.
- m_valid  out  1  output element valid.
- m_ready  in  1  output element consumed when m_valid&m_ready.
- m_data  out  DATA_WIDTH  output element.
- m_last  out  1  high on element N-1.
- eng_tokens_flat  out  FLAT_W  engine input bus.
- eng_rst  out  1  engine reset.
- eng_start  out  1  engine start pulse.
- eng_done  in  1  engine done, sticky until eng_rst.
- eng_out_flat  in  FLAT_W  engine result bus.
- busy  out  1  state != IDLE.
- frame_err  out  1  sticky s_last mismatch flag.
- timeout  out  1  sticky watchdog flag.
- perf_cycles  out  32  cycles from eng_start to capture.

Function
REQ-004 Element k = token*EMBED_DIM + dim occupies bits [k*DATA_WIDTH +: DATA_WIDTH] on both flat buses; streams carry k = 0..N-1 in ascending order.
REQ-005 States IDLE, LOAD, CLR, KICK, WAIT, UNLOAD; held in a registered state variable.
REQ-006 IDLE/LOAD: s_ready=1; each handshake writes s_data to element idx and increments idx; accepting idx N-1 goes to CLR; the first beat in IDLE goes to LOAD (directly to CLR when N=1) and clears frame_err and timeout.
REQ-007 s_last=1 on a beat with idx != N-1, or s_last=0 on idx N-1, sets frame_err; the count is unaffected and the job proceeds.
REQ-008 CLR: eng_rst=1 for exactly one cycle; next state KICK.
REQ-009 KICK: eng_start=1 for exactly one cycle; watchdog and perf counter cleared; next state WAIT.
REQ-010 WAIT: eng_done sampled 1 -> capture eng_out_flat into output buffer, freeze perf_cycles, go to UNLOAD; watchdog reaching TIMEOUT_CYCLES first -> set timeout, go to IDLE, no output emitted.
REQ-011 UNLOAD: m_valid=1, m_data=buffer element odx, m_last=(odx==N-1); m_data and m_last are stable while m_valid&!m_ready; handshake on N-1 -> IDLE.
REQ-012 s_ready=0 in CLR, KICK, WAIT and UNLOAD; m_valid=0 outside UNLOAD.
REQ-013 eng_tokens_flat is driven from the input buffer and stays stable from CLR until the next LOAD write.
REQ-014 Throughput is one element per cycle in each direction; latency is WAIT duration + 3 cycles from the last input beat to first m_valid.

Reset
REQ-015 rst=1 -> state IDLE, idx=odx=0, s_ready=0, m_valid=0, m_last=0, eng_start=0, eng_rst=1, busy=0, frame_err=0, timeout=0, perf_cycles=0; buffers are not cleared.
REQ-016 rst mid-job abandons the job in any state; the first cycle after release is IDLE with s_ready=1.

Configuration
REQ-017 Macro ATTN_BRIDGE_PERF_EN defined: perf_cycles counts every WAIT cycle, saturating at 2^32-1; undefined: counter logic is absent and perf_cycles is constant 0.

Structure
REQ-018 Package attn_pkg holds the bridge state enum, the element-index type sized $clog2(N+1), and the flat-offset helper function.
REQ-019 Sub-module attn_watchdog (clear, enable, limit -> expired) implements the WAIT timeout.

Verification
REQ-020 Parameters DATA_WIDTH=16, SEQ_LEN=2, EMBED_DIM=2, TIMEOUT_CYCLES=8; engine model raises eng_done 3 cycles after eng_start with out = in + 1.
REQ-021 Stream 0x0001,0x0002,0x0003,0x0004 with s_last on beat 4 -> one eng_rst pulse, then one eng_start pulse; output 0x0002..0x0005 with m_last only on beat 4; frame_err=0.
REQ-022 Random m_ready stalls (~50% duty) -> no element lost or duplicated; m_data is constant across each stall.
REQ-023 s_last on beat 2 -> frame_err=1, four elements still loaded, output still 4 beats; next job's first beat clears frame_err.
REQ-024 Engine never asserts done -> timeout=1 after 8 WAIT cycles, return to IDLE, m_valid stays 0.
REQ-025 rst pulsed during UNLOAD after beat 2 -> m_valid=0 next cycle, busy=0; a new 4-beat job completes correctly.
REQ-026 With ATTN_BRIDGE_PERF_EN, REQ-021 yields perf_cycles=3; without the macro, perf_cycles=0.
